// File: rtl/tutorial_pkg.sv
// Shared types for the tutorial serial datapath blocks.
// Holds the common FSM state type used by bit-serial units.
package tutorial_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - BI, BO is the borrow out.
// Pure combinational counterpart of the tutorial full adder.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  always_comb begin
    D  = A ^ B ^ BI;
    BO = (~A & B) | (~(A ^ B) & BI);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: LSB first, one bit per clock through a single full subtractor.
// START/BUSY/DONE handshake; D/BO are updated only when a result completes.
module serial_subtractor
  import tutorial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d, bo_q, bo_d;
  logic             bit_d, bit_bo;

  full_subtractor u_cell (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .BI (borrow_q),
    .D  (bit_d),
    .BO (bit_bo)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bo_d     = bo_q;
    case (state_q)
      IDLE, FIN: begin
        // FIN accepts a new request too, giving back-to-back operation
        if (START) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        borrow_d = bit_bo;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d   = '0;
          d_d     = res_d;
          bo_d    = bit_bo;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);
  assign D    = d_q;
  assign BO   = bo_q;

endmodule
